mem_arbiter: RTL and testbench

Shares the single 32-bit, byte-addressed, 1 MB unified memory between the instruction-fetch port and the load/store port of the MIPS pipeline. It arbitrates round-robin between the two ports and sequences each access into memory cycles. Sub-word stores become read-modify-write sequences. Misaligned or out-of-range requests are rejected without touching memory. It sits between the fetch/memory pipeline stages and the memory model.

---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 32-bit big-endian memory between the fetch
// and load/store ports; sub-word stores are sequenced as read-modify-write.
module mem_arbiter #(
    parameter int unsigned MEM_DEPTH = 1048576
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_wren,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wren,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, MERGE, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    state_t      state, state_n;

    // Request fields latched at grant
    logic        gnt_d;
    logic        prio_d;
    logic        l_wren;
    logic        l_signed;
    logic        l_err;
    logic [1:0]  l_size;
    logic [1:0]  l_off;
    logic [31:0] l_wdata;

    logic        any_req;
    logic        pick_d;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic        sel_wren;
    logic [2:0]  sel_bytes;
    logic [32:0] sel_end;
    logic        sel_err;

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [4:0]  sh;
    logic [31:0] lane_mask;
    logic [31:0] merged;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] loaded;
    logic        port_n;
    logic [31:0] result_n;

    // Arbitration and request validation, evaluated for the port that would be granted
    always_comb begin
        any_req  = i_req | d_req;
        pick_d   = d_req & (~i_req | prio_d);
        sel_addr = pick_d ? d_addr : i_addr;
        sel_size = pick_d ? d_size : SZ_WORD;
        sel_wren = pick_d & d_wren;
        case (sel_size)
            SZ_BYTE: sel_bytes = 3'd1;
            SZ_HALF: sel_bytes = 3'd2;
            default: sel_bytes = 3'd4;
        endcase
        sel_end = {1'b0, sel_addr} + {30'd0, sel_bytes};
        sel_err = (sel_size == SZ_BAD)
                | ((sel_size == SZ_HALF) & sel_addr[0])
                | ((sel_size == SZ_WORD) & (|sel_addr[1:0]))
                | (sel_end > 33'(MEM_DEPTH));
    end

    // Big-endian lane selection: offset 0 is the most significant byte/halfword
    always_comb begin
        bsh       = {~l_off, 3'b000};
        hsh       = {~l_off[1], 4'b0000};
        sh        = (l_size == SZ_BYTE) ? bsh : hsh;
        lane_mask = (l_size == SZ_BYTE) ? (32'h0000_00FF << sh) : (32'h0000_FFFF << sh);
        merged    = (mem_rdata & ~lane_mask) | ((l_wdata << sh) & lane_mask);
        byte_v    = mem_rdata[bsh +: 8];
        half_v    = mem_rdata[hsh +: 16];
        case (l_size)
            SZ_BYTE: loaded = l_signed ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
            SZ_HALF: loaded = l_signed ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
            default: loaded = mem_rdata;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any_req) state_n = sel_err ? DONE : ISSUE;
            ISSUE:   state_n = (l_wren && (l_size == SZ_WORD)) ? DONE : WAIT;
            WAIT:    state_n = l_wren ? MERGE : DONE;
            MERGE:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        port_n   = (state == IDLE) ? pick_d : gnt_d;
        result_n = ((state == WAIT) && !l_wren) ? loaded : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // mem_wren is a one-cycle registered strobe; it is raised only for ISSUE of a
    // word store or for MERGE, so the write lands on the edge ending that state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt_d     <= 1'b0;
            prio_d    <= 1'b1;
            l_wren    <= 1'b0;
            l_signed  <= 1'b0;
            l_err     <= 1'b0;
            l_size    <= '0;
            l_off     <= '0;
            l_wdata   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            mem_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_d    <= pick_d;
                        prio_d   <= ~pick_d;
                        l_off    <= sel_addr[1:0];
                        l_size   <= sel_size;
                        l_wren   <= sel_wren;
                        l_signed <= pick_d & d_signed;
                        l_wdata  <= d_wdata;
                        l_err    <= sel_err;
                        if (!sel_err) begin
                            mem_addr <= {sel_addr[31:2], 2'b00};
                            if (sel_wren && (sel_size == SZ_WORD)) begin
                                mem_wren  <= 1'b1;
                                mem_wdata <= d_wdata;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (l_wren) begin
                        mem_wren  <= 1'b1;
                        mem_wdata <= merged;
                    end
                end
                default: ;
            endcase
            if ((state_n == DONE) && (state != DONE)) begin
                if (port_n) d_rdata <= result_n;
                else        i_rdata <= result_n;
            end
        end
    end

    assign i_ack = (state == DONE) & ~gnt_d;
    assign d_ack = (state == DONE) & gnt_d;
    assign i_err = i_ack & l_err;
    assign d_err = d_ack & l_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-level reference memory and round-robin model,
// directed scenarios followed by randomized traffic on both ports.
module tb_mem_arbiter;

    localparam int unsigned MEM_DEPTH = 1048576;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic        d_wren = 1'b0;
    logic [1:0]  d_size = 2'b10;
    logic        d_signed = 1'b0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wren;
    logic [31:0] mem_rdata = '0;

    always #5 clock = ~clock;

    mem_arbiter #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_wren(d_wren), .d_size(d_size),
        .d_signed(d_signed), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
    );

    // Memory environment: synchronous read, write on rising edge
    logic [31:0] mem [0:MEM_DEPTH/4-1];
    int          wr_cnt = 0;
    bit          both_ack = 1'b0;

    initial for (int w = 0; w < int'(MEM_DEPTH / 4); w++) mem[w] = '0;

    always @(posedge clock) begin
        if (mem_wren) begin
            mem[mem_addr[19:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        mem_rdata <= mem[mem_addr[19:2]];
    end

    always @(negedge clock) if (i_ack && d_ack) both_ack <= 1'b1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference model: flat byte array plus the priority holder
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  refb [int unsigned];
    bit          ref_prio_d = 1'b1;

    function automatic logic [7:0] rb(input int unsigned a);
        return refb.exists(a) ? refb[a] : 8'h00;
    endfunction

    function automatic int unsigned nbytes(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_err(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'b11) return 1'b1;
        if (s == 2'b01 && (a % 2) != 0) return 1'b1;
        if (s == 2'b10 && (a % 4) != 0) return 1'b1;
        return (64'(a) + 64'(nbytes(s))) > 64'(MEM_DEPTH);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input bit sg);
        logic [31:0] v;
        int unsigned n;
        v = '0;
        n = nbytes(s);
        for (int unsigned k = 0; k < n; k++) v = (v << 8) | {24'd0, rb(a + k)};
        if (sg && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sg && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] w);
        int unsigned n;
        n = nbytes(s);
        for (int unsigned k = 0; k < n; k++) refb[a + k] = 8'(w >> (8 * (n - 1 - k)));
    endtask

    // Cycles from the raising negedge to the ack negedge when granted immediately
    function automatic int latency(input bit e, input bit wr, input logic [1:0] s);
        if (e) return 1;
        if (wr) return (s == 2'b10) ? 2 : 4;
        return 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_i_ack", 32'(i_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_i_err", 32'(i_err), 32'd0);
        check("rst_d_err", 32'(d_err), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wren", 32'(mem_wren), 32'd0);
    endtask

    task automatic set_d(input logic [31:0] a, input bit w, input logic [1:0] s,
                         input bit sg, input logic [31:0] wd);
        d_addr = a; d_wren = w; d_size = s; d_signed = sg; d_wdata = wd;
    endtask

    // Serves the requests already raised, predicting grant order from the model
    task automatic serve(input bit use_i, input bit use_d);
        bit          pend_i, pend_d, exp_d, e, wr, sg;
        logic [31:0] a, exp_rd;
        logic [1:0]  s;
        int          n, exp_n, w0, nport;
        pend_i = use_i;
        pend_d = use_d;
        nport = int'(use_i) + int'(use_d);
        for (int t = 0; t < nport; t++) begin
            exp_d  = (pend_i && pend_d) ? ref_prio_d : pend_d;
            a      = exp_d ? d_addr : i_addr;
            s      = exp_d ? d_size : 2'b10;
            wr     = exp_d && d_wren;
            sg     = exp_d && d_signed;
            e      = model_err(a, s);
            exp_n  = latency(e, wr, s) + t;
            exp_rd = e ? 32'd0 : model_load(a, s, sg);
            w0 = wr_cnt;
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!(i_ack || d_ack) && n < 12);
            check("ack_seen", 32'(i_ack | d_ack), 32'd1);
            check("ack_port", 32'(d_ack), 32'(exp_d));
            check("latency", 32'(n), 32'(exp_n));
            check("err", 32'(exp_d ? d_err : i_err), 32'(e));
            if (!wr || e) check("rdata", exp_d ? d_rdata : i_rdata, exp_rd);
            check("mem_writes", 32'(wr_cnt - w0), 32'(wr && !e));
            if (wr && !e) model_store(a, s, d_wdata);
            ref_prio_d = !exp_d;
            if (exp_d) begin d_req = 1'b0; pend_d = 1'b0; end
            else       begin i_req = 1'b0; pend_i = 1'b0; end
        end
        @(negedge clock);
        check("ack_clear", {30'd0, i_ack, d_ack}, 32'd0);
    endtask

    task automatic run(input bit use_i, input bit use_d);
        @(negedge clock);
        i_req = use_i;
        d_req = use_d;
        serve(use_i, use_d);
    endtask

    initial begin
        int          n, w0, off, sz, mode;
        bit          exp_d;
        logic [31:0] a;

        // Reset with both requests low
        repeat (3) @(negedge clock);
        check_reset_outputs();
        reset_n = 1'b1;

        set_d(32'h100, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF);
        run(1'b0, 1'b1);
        i_addr = 32'h100;
        run(1'b1, 1'b0);

        // Simultaneous requests held continuously after a fresh reset
        reset_n = 1'b0;
        @(negedge clock);
        check_reset_outputs();
        reset_n = 1'b1;
        ref_prio_d = 1'b1;
        i_addr = 32'h100;
        set_d(32'h100, 1'b0, 2'b10, 1'b0, 32'h0);
        @(negedge clock);
        i_req = 1'b1;
        d_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_d = ref_prio_d;
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!(i_ack || d_ack) && n < 12);
            check("alt_port", 32'(d_ack), 32'(exp_d));
            check("alt_latency", 32'(n), (g == 0) ? 32'd3 : 32'd4);
            check("alt_rdata", exp_d ? d_rdata : i_rdata, model_load(32'h100, 2'b10, 1'b0));
            ref_prio_d = !exp_d;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clock);

        // Byte read-modify-write and sub-word loads
        set_d(32'h200, 1'b1, 2'b10, 1'b0, 32'h1122_3344); run(1'b0, 1'b1);
        set_d(32'h201, 1'b1, 2'b00, 1'b0, 32'h0000_00AA); run(1'b0, 1'b1);
        set_d(32'h200, 1'b0, 2'b10, 1'b0, 32'h0);         run(1'b0, 1'b1);
        set_d(32'h201, 1'b0, 2'b00, 1'b1, 32'h0);         run(1'b0, 1'b1);
        set_d(32'h201, 1'b0, 2'b00, 1'b0, 32'h0);         run(1'b0, 1'b1);

        // Halfword read-modify-write
        set_d(32'h200, 1'b1, 2'b10, 1'b0, 32'h1122_3344); run(1'b0, 1'b1);
        set_d(32'h202, 1'b1, 2'b01, 1'b0, 32'h0000_BEEF); run(1'b0, 1'b1);
        set_d(32'h200, 1'b0, 2'b10, 1'b0, 32'h0);         run(1'b0, 1'b1);
        set_d(32'h202, 1'b0, 2'b01, 1'b1, 32'h0);         run(1'b0, 1'b1);
        set_d(32'h200, 1'b0, 2'b01, 1'b1, 32'h0);         run(1'b0, 1'b1);

        // Rejected requests and range boundaries
        set_d(32'h102, 1'b0, 2'b10, 1'b0, 32'h0);           run(1'b0, 1'b1);
        set_d(32'h101, 1'b0, 2'b01, 1'b0, 32'h0);           run(1'b0, 1'b1);
        set_d(32'h100, 1'b0, 2'b11, 1'b0, 32'h0);           run(1'b0, 1'b1);
        set_d(32'h100, 1'b1, 2'b11, 1'b0, 32'h1234_5678);   run(1'b0, 1'b1);
        set_d(MEM_DEPTH - 2, 1'b0, 2'b10, 1'b0, 32'h0);     run(1'b0, 1'b1);
        set_d(MEM_DEPTH, 1'b1, 2'b00, 1'b0, 32'h0000_0055); run(1'b0, 1'b1);
        set_d(32'hFFFF_FFFC, 1'b1, 2'b10, 1'b0, 32'hCAFE_F00D); run(1'b0, 1'b1);
        i_addr = 32'h102;                                   run(1'b1, 1'b0);
        set_d(MEM_DEPTH - 4, 1'b1, 2'b10, 1'b0, 32'hA1B2_C3D4); run(1'b0, 1'b1);
        set_d(MEM_DEPTH - 1, 1'b1, 2'b00, 1'b0, 32'h0000_0099); run(1'b0, 1'b1);
        set_d(MEM_DEPTH - 2, 1'b0, 2'b01, 1'b1, 32'h0);     run(1'b0, 1'b1);
        i_addr = MEM_DEPTH - 4;                             run(1'b1, 1'b0);

        // Reset asserted while a byte store sits in WAIT
        set_d(32'h300, 1'b1, 2'b10, 1'b0, 32'h5566_7788); run(1'b0, 1'b1);
        set_d(32'h300, 1'b1, 2'b00, 1'b0, 32'h0000_00CC);
        @(negedge clock);
        d_req = 1'b1;
        w0 = wr_cnt;
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        check("rst_mid_d_ack", 32'(d_ack), 32'd0);
        set_d(32'h300, 1'b0, 2'b10, 1'b0, 32'h0);
        repeat (2) begin
            @(negedge clock);
            check_reset_outputs();
        end
        check("rst_mid_no_write", 32'(wr_cnt - w0), 32'd0);
        ref_prio_d = 1'b1;
        reset_n = 1'b1;
        serve(1'b0, 1'b1);

        // Randomized traffic on both ports
        for (int it = 0; it < 150; it++) begin
            mode = $urandom_range(0, 2);
            sz = $urandom_range(0, 3);
            off = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 1) off = off & 2;
                if (sz == 2) off = 0;
            end
            if ($urandom_range(0, 9) == 0) a = MEM_DEPTH - $urandom_range(1, 8);
            else a = 32'h400 + 32'($urandom_range(0, 15) * 4 + off);
            set_d(a, 1'($urandom_range(0, 1)), 2'(sz), 1'($urandom_range(0, 1)), $urandom);
            i_addr = 32'h400 + 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) i_addr = i_addr + 32'($urandom_range(1, 3));
            run(mode != 1, mode != 0);
        end

        check("no_dual_ack", 32'(both_ack), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
